// File: rtl/lm_sm_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// lm_sm_sequencer_pkg
// Purpose : shared ISA constants for the LM/SM micro-sequencer: opcode values,
//           ALU operation encodings, register count and the sequencer state
//           encoding.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package lm_sm_sequencer_pkg;

  // Opcodes held in instr[15:12]
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  // ALU operation encodings
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NAND = 2'b01;
  localparam logic [1:0] ALU_NOP  = 2'b10;

  // Architectural register count (width of the register list)
  localparam int NREG = 8;

  // Sequencer states
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  // True when the opcode field selects a load-multiple or store-multiple
  function automatic logic is_lm_sm(input logic [15:0] instr);
    return (instr[15:12] == OP_LM) || (instr[15:12] == OP_SM);
  endfunction

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// -----------------------------------------------------------------------------
// lm_sm_sequencer_if
// Purpose : bundles the decode-side inputs and micro-op outputs of the LM/SM
//           sequencer.
// Signals : instr_in/instr_valid  instruction from decode
//           stall_in/flush        pipeline control
//           stall_fetch           hold fetch/decode (combinational)
//           uop_*                 registered micro-op fields
// Modports: master = decode/pipeline side, slave = sequencer.
// -----------------------------------------------------------------------------
interface lm_sm_sequencer_if #(
  parameter int DATA_W = 16
);
  logic [15:0]       instr_in;
  logic              instr_valid;
  logic              stall_in;
  logic              flush;
  logic              stall_fetch;
  logic              uop_valid;
  logic [2:0]        uop_reg_idx;
  logic [2:0]        uop_base_idx;
  logic [DATA_W-1:0] uop_offset;
  logic [1:0]        uop_alu_op;
  logic              uop_reg_write_en;
  logic              uop_mem_write_en;
  logic              uop_last;

  modport master (
    output instr_in, instr_valid, stall_in, flush,
    input  stall_fetch, uop_valid, uop_reg_idx, uop_base_idx, uop_offset,
           uop_alu_op, uop_reg_write_en, uop_mem_write_en, uop_last
  );

  modport slave (
    input  instr_in, instr_valid, stall_in, flush,
    output stall_fetch, uop_valid, uop_reg_idx, uop_base_idx, uop_offset,
           uop_alu_op, uop_reg_write_en, uop_mem_write_en, uop_last
  );
endinterface

// File: rtl/lm_sm_sequencer_prio_enc8.sv
// -----------------------------------------------------------------------------
// prio_enc8
// Purpose : combinational priority encoder over an LM/SM register list.
//           List bit (7-k) selects Rk; the lowest-numbered selected register
//           wins.
// Ports   : i_list      register list in instruction bit order
//           o_found     at least one register selected
//           o_idx       index k of the lowest selected Rk
//           o_next_list i_list with the winning bit cleared
// -----------------------------------------------------------------------------
module prio_enc8 (
  input  logic [7:0] i_list,
  output logic       o_found,
  output logic [2:0] o_idx,
  output logic [7:0] o_next_list
);

  logic [7:0] w_rk;       // bit k set when Rk is selected
  logic [7:0] w_onehot;   // lowest set bit of w_rk
  logic [7:0] w_next_rk;

  // Reorder the list so that bit k corresponds to Rk
  always_comb begin
    w_rk = 8'h00;
    for (int k = 0; k < 8; k++) begin
      w_rk[k] = i_list[7-k];
    end
  end

  // Two's-complement trick isolates the lowest set bit
  assign w_onehot  = w_rk & (~w_rk + 8'd1);
  assign w_next_rk = w_rk & ~w_onehot;
  assign o_found   = |w_rk;

  // Encode the isolated bit and map the remaining set back to list order
  always_comb begin
    o_next_list = 8'h00;
    for (int k = 0; k < 8; k++) begin
      o_next_list[7-k] = w_next_rk[k];
    end
    case (w_onehot)
      8'h01:   o_idx = 3'd0;
      8'h02:   o_idx = 3'd1;
      8'h04:   o_idx = 3'd2;
      8'h08:   o_idx = 3'd3;
      8'h10:   o_idx = 3'd4;
      8'h20:   o_idx = 3'd5;
      8'h40:   o_idx = 3'd6;
      8'h80:   o_idx = 3'd7;
      default: o_idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/lm_sm_sequencer.sv
// -----------------------------------------------------------------------------
// lm_sm_sequencer
// Purpose : expands one IITB-RISC LM/SM instruction into one address-generation
//           micro-op per selected register, stalling fetch/decode meanwhile.
//           The first micro-op is produced in the acceptance cycle itself, so
//           it is visible on the outputs the cycle after acceptance.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    lm_sm_sequencer_if.slave (instruction in, micro-op out)
// -----------------------------------------------------------------------------
import lm_sm_sequencer_pkg::*;

module lm_sm_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input logic              clk,
  input logic              rst_n,
  lm_sm_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(NREG + 1);

  // Sequencer state
  logic [0:0]      r_state;
  logic [NREG-1:0] r_mask;    // remaining list, instruction bit order
  logic [CNT_W-1:0] r_count;  // micro-ops already issued
  logic            r_is_sm;
  logic [2:0]      r_base;

  // Registered micro-op outputs
  logic              r_uop_valid;
  logic [2:0]        r_uop_reg_idx;
  logic [2:0]        r_uop_base_idx;
  logic [DATA_W-1:0] r_uop_offset;
  logic              r_uop_reg_write_en;
  logic              r_uop_mem_write_en;
  logic              r_uop_last;

  logic [NREG-1:0]  w_enc_in;
  logic             w_found;
  logic [2:0]       w_idx;
  logic [NREG-1:0]  w_next_mask;
  logic             w_accept;
  logic             w_issue;
  logic             w_last_issue;
  logic             w_stall_fetch;
  logic [CNT_W-1:0] w_cur_count;
  logic             w_cur_sm;
  logic [2:0]       w_cur_base;
  logic             w_unused_bit8;

  assign w_unused_bit8 = bus.instr_in[8];

  // In IDLE the encoder looks at the incoming list so the first micro-op can
  // be issued in the acceptance cycle; in ISSUE it looks at what remains.
  assign w_enc_in = (r_state == ST_IDLE) ? bus.instr_in[NREG-1:0] : r_mask;

  prio_enc8 u_prio_enc8 (
    .i_list      (w_enc_in),
    .o_found     (w_found),
    .o_idx       (w_idx),
    .o_next_list (w_next_mask)
  );

  // Acceptance, issue and stall_fetch decisions for the current cycle
  always_comb begin
    w_accept      = 1'b0;
    w_issue       = 1'b0;
    w_last_issue  = 1'b0;
    w_stall_fetch = 1'b0;
    w_cur_count   = '0;
    w_cur_sm      = 1'b0;
    w_cur_base    = 3'd0;
    if (r_state == ST_IDLE) begin
      w_accept    = bus.instr_valid && is_lm_sm(bus.instr_in) &&
                    !bus.flush && !bus.stall_in;
      w_issue     = w_accept && w_found;
      w_cur_count = '0;
      w_cur_sm    = (bus.instr_in[15:12] == OP_SM);
      w_cur_base  = bus.instr_in[11:9];
    end else begin
      w_accept    = 1'b0;
      w_issue     = w_found && !bus.flush && !bus.stall_in;
      w_cur_count = r_count;
      w_cur_sm    = r_is_sm;
      w_cur_base  = r_base;
    end
    w_last_issue = w_issue && (w_next_mask == '0);
    // Decode is released in the same cycle the final micro-op is generated
    if (!rst_n || bus.flush) begin
      w_stall_fetch = 1'b0;
    end else if (r_state == ST_ISSUE) begin
      w_stall_fetch = !w_last_issue;
    end else begin
      w_stall_fetch = w_issue && !w_last_issue;
    end
  end

  // Sequencer state: flush beats stall, stall freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_count <= '0;
      r_is_sm <= 1'b0;
      r_base  <= 3'd0;
    end else if (bus.flush) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_count <= '0;
    end else if (bus.stall_in) begin
      r_state <= r_state;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // A single-register list completes right here and stays in IDLE
            r_mask  <= w_next_mask;
            r_base  <= bus.instr_in[11:9];
            r_is_sm <= (bus.instr_in[15:12] == OP_SM);
            r_count <= w_found ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
            r_state <= (w_found && (w_next_mask != '0)) ? ST_ISSUE : ST_IDLE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_mask  <= w_next_mask;
          r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
          r_state <= (w_next_mask == '0) ? ST_IDLE : ST_ISSUE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_mask  <= '0;
          r_count <= '0;
        end
      endcase
    end
  end

  // Micro-op output register; address fields hold in idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uop_valid        <= 1'b0;
      r_uop_reg_idx      <= 3'd0;
      r_uop_base_idx     <= 3'd0;
      r_uop_offset       <= '0;
      r_uop_reg_write_en <= 1'b0;
      r_uop_mem_write_en <= 1'b0;
      r_uop_last         <= 1'b0;
    end else if (bus.flush) begin
      r_uop_valid        <= 1'b0;
      r_uop_reg_write_en <= 1'b0;
      r_uop_mem_write_en <= 1'b0;
      r_uop_last         <= 1'b0;
    end else if (bus.stall_in) begin
      r_uop_valid <= r_uop_valid;
    end else if (w_issue) begin
      r_uop_valid        <= 1'b1;
      r_uop_reg_idx      <= w_idx;
      r_uop_base_idx     <= w_cur_base;
      r_uop_offset       <= {{(DATA_W-CNT_W){1'b0}}, w_cur_count};
      r_uop_reg_write_en <= !w_cur_sm;
      r_uop_mem_write_en <= w_cur_sm;
      r_uop_last         <= w_last_issue;
    end else begin
      r_uop_valid        <= 1'b0;
      r_uop_reg_write_en <= 1'b0;
      r_uop_mem_write_en <= 1'b0;
      r_uop_last         <= 1'b0;
    end
  end

  assign bus.stall_fetch      = w_stall_fetch;
  assign bus.uop_valid        = r_uop_valid;
  assign bus.uop_reg_idx      = r_uop_reg_idx;
  assign bus.uop_base_idx     = r_uop_base_idx;
  assign bus.uop_offset       = r_uop_offset;
  assign bus.uop_alu_op       = ALU_ADD;
  assign bus.uop_reg_write_en = r_uop_reg_write_en;
  assign bus.uop_mem_write_en = r_uop_mem_write_en;
  assign bus.uop_last         = r_uop_last;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lm_sm_sequencer
// Purpose : self-checking bench for lm_sm_sequencer. A queue-based reference
//           model predicts every cycle's outputs; directed scenarios add
//           literal expectations, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_lm_sm_sequencer;
  import lm_sm_sequencer_pkg::*;

  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lm_sm_sequencer_if #(.DATA_W(DATA_W)) bus ();

  lm_sm_sequencer #(.DATA_W(DATA_W), .NREG(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int idx;
    int off;
    bit last;
    bit sm;
  } ev_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int   q[$];          // registers still to transfer, in issue order
  bit   busy;
  int   m_cnt;
  bit   m_sm;
  int   m_base;
  bit   e_valid, e_last, e_rwe, e_mwe;
  int   e_idx, e_base, e_off;
  ev_t  log_q[$];      // every micro-op the model issued
  int   sf_cnt;        // cycles with stall_fetch high
  int   r1_seen;       // cycles with a valid R1 micro-op on the outputs

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 1'b0; q.delete(); m_cnt = 0; m_sm = 1'b0; m_base = 0;
    e_valid = 1'b0; e_last = 1'b0; e_rwe = 1'b0; e_mwe = 1'b0;
    e_idx = 0; e_base = 0; e_off = 0;
  endtask

  function automatic bit exp_stall_fetch();
    if (!rst_n || bus.flush) return 1'b0;
    if (busy) return bus.stall_in ? 1'b1 : (q.size() > 1);
    if (bus.instr_valid && !bus.stall_in && is_lm_sm(bus.instr_in))
      return $countones(bus.instr_in[7:0]) >= 2;
    return 1'b0;
  endfunction

  task automatic model_step();
    ev_t ev;
    if (bus.flush) begin
      busy = 1'b0; q.delete();
      e_valid = 1'b0; e_last = 1'b0; e_rwe = 1'b0; e_mwe = 1'b0;
    end else if (!bus.stall_in) begin
      if (!busy && bus.instr_valid && is_lm_sm(bus.instr_in)) begin
        q.delete();
        for (int k = 0; k < NREG; k++)
          if (bus.instr_in[7-k]) q.push_back(k);
        m_cnt  = 0;
        m_sm   = (bus.instr_in[15:12] == OP_SM);
        m_base = int'(bus.instr_in[11:9]);
        busy   = (q.size() != 0);
      end
      if (busy) begin
        e_idx   = q.pop_front();
        e_valid = 1'b1;
        e_base  = m_base;
        e_off   = m_cnt;
        e_rwe   = !m_sm;
        e_mwe   = m_sm;
        e_last  = (q.size() == 0);
        m_cnt++;
        if (q.size() == 0) busy = 1'b0;
        ev.idx = e_idx; ev.off = e_off; ev.last = e_last; ev.sm = m_sm;
        log_q.push_back(ev);
      end else begin
        e_valid = 1'b0; e_last = 1'b0; e_rwe = 1'b0; e_mwe = 1'b0;
      end
    end
  endtask

  // Compare every cycle on the falling edge, then advance the model
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("uop_valid", bus.uop_valid, e_valid);
    chk("uop_last", bus.uop_last, e_last);
    chk("uop_reg_write_en", bus.uop_reg_write_en, e_rwe);
    chk("uop_mem_write_en", bus.uop_mem_write_en, e_mwe);
    chk("uop_alu_op", bus.uop_alu_op, ALU_ADD);
    if (e_valid) begin
      chk("uop_reg_idx", bus.uop_reg_idx, e_idx);
      chk("uop_base_idx", bus.uop_base_idx, e_base);
      chk("uop_offset", bus.uop_offset, e_off);
    end
    chk("stall_fetch", bus.stall_fetch, exp_stall_fetch());
    if (bus.stall_fetch) sf_cnt++;
    if (bus.uop_valid && bus.uop_reg_idx == 3'd1) r1_seen++;
    if (rst_n) model_step();
  end

  task automatic drive(input logic [15:0] ins, input bit v, input bit st, input bit fl);
    @(posedge clk); #1;
    bus.instr_in = ins; bus.instr_valid = v; bus.stall_in = st; bus.flush = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  // Present an instruction and hold it while decode is stalled (bounded)
  task automatic present(input logic [15:0] ins);
    bit done;
    done = 1'b0;
    drive(ins, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 20 && !done; c++) begin
      #2;
      if (!bus.stall_fetch) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("present_timeout", done, 1'b1);
  endtask

  task automatic chk_ev(input string nm, input int i, input int idx, input int off,
                        input bit last, input bit sm);
    if (i < log_q.size())
      chk(nm, {log_q[i].idx[7:0], log_q[i].off[7:0], 6'd0, log_q[i].last, log_q[i].sm},
          {idx[7:0], off[7:0], 6'd0, last, sm});
    else
      chk({nm, "_missing"}, log_q.size(), i + 1);
  endtask

  task automatic clear_logs();
    log_q.delete(); sf_cnt = 0; r1_seen = 0;
  endtask

  logic [15:0] rins;
  logic [3:0]  rop;
  logic [7:0]  rlist;
  int          sel;

  initial begin
    model_reset();
    clear_logs();
    bus.instr_in = 16'h0000; bus.instr_valid = 1'b0; bus.stall_in = 1'b0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", bus.uop_valid, 1'b0);
    chk("reset_stall_fetch", bus.stall_fetch, 1'b0);
    chk("reset_offset", bus.uop_offset, 16'h0000);
    rst_n = 1'b1;
    idle(2);

    // LM base R3, list R0+R7
    clear_logs();
    drive(16'h6681, 1'b1, 1'b0, 1'b0);
    idle(4);
    chk("t1_count", log_q.size(), 2);
    chk_ev("t1_ev0", 0, 0, 0, 1'b0, 1'b0);
    chk_ev("t1_ev1", 1, 7, 1, 1'b1, 1'b0);
    chk("t1_stall_cycles", sf_cnt, 1);

    // SM base R1, all registers
    clear_logs();
    drive(16'h72FF, 1'b1, 1'b0, 1'b0);
    idle(10);
    chk("t2_count", log_q.size(), 8);
    chk_ev("t2_ev0", 0, 0, 0, 1'b0, 1'b1);
    chk_ev("t2_ev6", 6, 6, 6, 1'b0, 1'b1);
    chk_ev("t2_ev7", 7, 7, 7, 1'b1, 1'b1);
    chk("t2_stall_cycles", sf_cnt, 7);

    // Empty LM retires as NOP; next LM (R7 only) accepted right after
    clear_logs();
    drive(16'h6600, 1'b1, 1'b0, 1'b0);
    drive(16'h6001, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("t3_count", log_q.size(), 1);
    chk_ev("t3_ev0", 0, 7, 0, 1'b1, 1'b0);
    chk("t3_stall_cycles", sf_cnt, 0);

    // SM R0..R3 with a 3-cycle downstream stall after the second micro-op
    clear_logs();
    drive(16'h74F0, 1'b1, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(16'h0000, 1'b0, 1'b1, 1'b0);
    idle(5);
    chk("t4_count", log_q.size(), 4);
    chk_ev("t4_ev3", 3, 3, 3, 1'b1, 1'b1);
    chk("t4_r1_held", r1_seen, 4);

    // LM all registers, flush after the third micro-op, then LM R7 only
    clear_logs();
    drive(16'h60FF, 1'b1, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0, 1'b1);
    drive(16'h6001, 1'b1, 1'b0, 1'b0);
    chk("t5_flush_valid", bus.uop_valid, 1'b0);
    idle(3);
    chk("t5_count", log_q.size(), 4);
    chk_ev("t5_ev2", 2, 2, 2, 1'b0, 1'b0);
    chk_ev("t5_ev3", 3, 7, 0, 1'b1, 1'b0);

    // Asynchronous reset mid-sequence, then back-to-back LM and SM
    drive(16'h70FF, 1'b1, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", bus.uop_valid, 1'b0);
    chk("t6_async_offset", bus.uop_offset, 16'h0000);
    chk("t6_async_mwe", bus.uop_mem_write_en, 1'b0);
    chk("t6_async_stall", bus.stall_fetch, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    clear_logs();
    present(16'h6A0F);
    present(16'h7C81);
    idle(4);
    chk("t6_count", log_q.size(), 6);
    chk_ev("t6_ev0", 0, 4, 0, 1'b0, 1'b0);
    chk_ev("t6_ev3", 3, 7, 3, 1'b1, 1'b0);
    chk_ev("t6_ev4", 4, 0, 0, 1'b0, 1'b1);
    chk_ev("t6_ev5", 5, 7, 1, 1'b1, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 3);
      rop = (sel == 0) ? OP_LM : (sel == 1) ? OP_SM : (sel == 2) ? OP_LM
                                                   : 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 7);
      rlist = (sel == 0) ? 8'h00 : (sel == 1) ? 8'(8'h01 << $urandom_range(0, 7))
                                              : 8'($urandom_range(0, 255));
      rins = {rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rlist};
      drive(rins, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
            $urandom_range(0, 99) < 4);
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
